// File: rtl/main_memory.sv
// Line-granular backing memory for a cache: one request outstanding, fixed access latency.
// Latency: response pulse LATENCY cycles after acceptance; next request accepted from cycle LATENCY+1.
// Backpressure: mem_req_ready low while busy; responses are never stalled.
module main_memory #(
  parameter int LINE_ADDR_W = 12,
  parameter int LINE_W      = 128,
  parameter int LATENCY     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_req_valid,
  output logic                   mem_req_ready,
  input  logic                   mem_req_we,
  input  logic [LINE_ADDR_W-1:0] mem_req_addr,
  input  logic [LINE_W-1:0]      mem_req_wdata,
  output logic                   mem_resp_valid,
  output logic [LINE_W-1:0]      mem_resp_rdata,
  output logic                   busy
);

  localparam int CNT_W = 4;
  localparam int DEPTH = 1 << LINE_ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [LINE_ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]      wdata_q, wdata_d;
  logic                   mem_wr_en;
  logic                   accept;

  // Storage array; deliberately not reset so contents survive rst.
  logic [LINE_W-1:0]      mem_q [DEPTH];

  assign mem_req_ready = (state_q == IDLE) && !rst;
  assign accept        = mem_req_valid && mem_req_ready;
  assign busy          = (state_q != IDLE);
  assign mem_resp_valid = (state_q == RESP);
  // Read data is driven only during the response cycle of a read, zero otherwise.
  assign mem_resp_rdata = ((state_q == RESP) && !we_q) ? mem_q[addr_q] : '0;

  // Next-state logic: latch request on acceptance, count down the latency, commit writes in RESP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mem_wr_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = mem_req_we;
          addr_d  = mem_req_addr;
          wdata_d = mem_req_wdata;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d   = IDLE;
        mem_wr_en = we_q;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and request-capture registers; reset aborts any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Array write at the edge that ends the response cycle of a write.
  always_ff @(posedge clk) begin
    if (mem_wr_en && !rst) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 SHALL have parameter LINE_ADDR_W, default 12, line-address width (ADDR_LENGTH - OFFSET_LENGTH = 16 - 4).
REQ-002 SHALL have parameter LINE_W, default 128, cache-line data width (CACHE_LINE_SIZE * 8).
REQ-003 SHALL have parameter LATENCY, default 4, access latency in cycles; legal range 1..15.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 mem_req_valid  input  1  cache presents a line request.
REQ-007 mem_req_ready  output  1  memory can accept a request this cycle.
REQ-008 mem_req_we  input  1  1 = line write-back, 0 = line refill read.
REQ-009 mem_req_addr  input  LINE_ADDR_W  line address {tag, index}.
REQ-010 mem_req_wdata  input  LINE_W  write-back line data.
REQ-011 mem_resp_valid  output  1  one-cycle completion pulse for reads and writes.
REQ-012 mem_resp_rdata  output  LINE_W  refill line data; valid only while mem_resp_valid=1 for a read.
REQ-013 busy  output  1  a request is in flight (state not IDLE).

Function
REQ-014 Storage SHALL be 2^LINE_ADDR_W entries of LINE_W bits (4096 x 128 = 64 kB); word order within a line: bits [31:0] = offset 0.
REQ-015 FSM states SHALL be IDLE, WAIT and RESP; mem_req_ready = 1 only in IDLE and not in reset.
REQ-016 Handshake: a request SHALL be accepted in the cycle where mem_req_valid = 1 and mem_req_ready = 1 (cycle 0); we, addr and wdata are latched at that edge.
REQ-017 Inputs SHALL be ignored whenever mem_req_ready = 0; only one request is outstanding at a time.
REQ-018 IDLE -> WAIT on acceptance when LATENCY > 1, loading a down-counter with LATENCY-1; IDLE -> RESP directly when LATENCY = 1.
REQ-019 In WAIT, the counter SHALL decrement each cycle; WAIT -> RESP when the counter reaches 1 at a clock edge.
REQ-020 mem_resp_valid SHALL be 1 for exactly one cycle: cycle LATENCY after acceptance (state RESP); RESP -> IDLE unconditionally.
REQ-021 Read: mem_resp_rdata in the RESP cycle SHALL equal the stored line at the latched address; outside RESP it is 0.
REQ-022 Write: the array SHALL be updated with the latched wdata at the clock edge ending the RESP cycle; mem_resp_rdata stays 0 for writes.
REQ-023 The next request SHALL be accepted no earlier than cycle LATENCY+1; a read issued after a write response returns the written data.
REQ-024 No backpressure on responses: the consumer SHALL sample mem_resp_valid when it is asserted.
REQ-025 Changes to mem_req_* inputs after acceptance SHALL NOT affect the in-flight operation.

Reset
REQ-026 While rst = 1: state = IDLE, counter = 0, mem_req_ready = 0, mem_resp_valid = 0, mem_resp_rdata = 0, busy = 0.
REQ-027 mem_req_ready SHALL rise in the first cycle after rst deasserts.
REQ-028 Reset asserted mid-operation SHALL abort the request immediately: no response pulse, and a pending write is not performed.
REQ-029 Reset SHALL NOT clear storage contents; the array is uninitialised at power-up.

Verification
REQ-030 Write addr 0x03A, wdata 0x0123_4567_89AB_CDEF_0011_2233_4455_6677, then read 0x03A -> read mem_resp_valid in cycle 4 after acceptance, rdata equals written line.
REQ-031 LATENCY = 4, back-to-back requests with mem_req_valid held high -> acceptances 5 cycles apart, busy = 1 for cycles 1..4, ready = 0 for those cycles.
REQ-032 Write 0xFFF (top line) and 0x000, then read both -> each returns its own data, with no wrap-around aliasing.
REQ-033 Assert rst in cycle 2 of a write to 0x010 (old data D0) -> no mem_resp_valid; after reset, read 0x010 returns D0.
REQ-034 LATENCY = 1 -> mem_resp_valid in cycle 1, ready = 1 again in cycle 2; inputs toggled during WAIT/RESP do not change the response.
